bin_layer_sequencer: RTL and testbench

//  Time-multiplexes one binary-weight dot-product lane group over all output neurons of a BNN layer.

---
 rtl/bin_layer_sequencer_pkg.sv | 30 +++
 rtl/bin_layer_sequencer_dot.sv | 31 +++
 rtl/bin_layer_sequencer.sv | 173 +++++++++++++++++
 tb/tb_bin_layer_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bin_layer_sequencer_pkg.sv
// Shared types and helpers for the binary-weight layer sequencer.
// Holds the sequencer state encoding and the output saturation function.
package bnn_pkg;

    localparam int BIT_CNT_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_EMIT,
        S_DONE
    } seq_state_e;

    // Clamp a wide signed accumulator into the signed range of bit_cnt bits.
    function automatic logic signed [31:0] sat_to_bit_cnt(input logic signed [31:0] acc,
                                                          input int bit_cnt);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bit_cnt - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (bit_cnt - 1));
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bin_layer_sequencer_dot.sv
// Combinational signed dot product of LANES activations with LANES binary weights.
// A weight bit of 1 adds the activation, 0 subtracts it.
module signed_bin_dot
    import bnn_pkg::*;
#(
    parameter int BIT_CNT = BIT_CNT_DEFAULT,
    parameter int LANES   = 4,
    parameter int ACC_W   = BIT_CNT + 5
) (
    input  logic [LANES*BIT_CNT-1:0] x,
    input  logic [LANES-1:0]         w,
    output logic signed [ACC_W-1:0]  sum
);

    // Widen before negating so that negating the most negative activation stays exact.
    function automatic logic signed [ACC_W-1:0] ext(input logic [BIT_CNT-1:0] v);
        return {{(ACC_W - BIT_CNT){v[BIT_CNT-1]}}, v};
    endfunction

    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w[k]) begin
                sum = sum + ext(x[k*BIT_CNT +: BIT_CNT]);
            end else begin
                sum = sum - ext(x[k*BIT_CNT +: BIT_CNT]);
            end
        end
    end

endmodule

// File: rtl/bin_layer_sequencer.sv
// Sequences one binary-weight dot-product lane group over every output neuron of a BNN layer:
// buffers activations, streams weight rows from external RAM, accumulates, saturates and emits.
module bin_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int BIT_CNT = BIT_CNT_DEFAULT,
    parameter int N_IN    = 16,
    parameter int N_OUT   = 10,
    parameter int LANES   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BIT_CNT-1:0]                        in_data,
    output logic                                      w_ren,
    output logic [$clog2(N_OUT*(N_IN/LANES))-1:0]     w_addr,
    input  logic [LANES-1:0]                          w_rdata,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic signed [BIT_CNT-1:0]                 out_data,
    output logic [$clog2(N_OUT)-1:0]                  out_idx
);

    localparam int CHUNKS = N_IN / LANES;
    localparam int AW     = $clog2(N_OUT * CHUNKS);
    localparam int ACC_W  = BIT_CNT + $clog2(N_IN) + 1;
    localparam int IDX_W  = $clog2(N_OUT);
    localparam int LOAD_W = $clog2(N_IN);
    localparam int ISS_W  = $clog2(CHUNKS + 1);

    seq_state_e state;
    seq_state_e state_next;

    logic [N_IN*BIT_CNT-1:0]   act_flat;
    logic [LOAD_W-1:0]         load_cnt;
    logic [ISS_W-1:0]          issue_cnt;
    logic [ISS_W-1:0]          rd_chunk;
    logic                      rd_valid;
    logic [AW-1:0]             row_addr;
    logic [IDX_W-1:0]          neuron;
    logic signed [ACC_W-1:0]   acc;
    logic [LANES*BIT_CNT-1:0]  lane_x;
    logic signed [ACC_W-1:0]   partial;

    signed_bin_dot #(
        .BIT_CNT (BIT_CNT),
        .LANES   (LANES),
        .ACC_W   (ACC_W)
    ) u_dot (
        .x   (lane_x),
        .w   (w_rdata),
        .sum (partial)
    );

    always_comb begin
        lane_x = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            if (rd_chunk == ISS_W'(c)) begin
                lane_x = act_flat[c*LANES*BIT_CNT +: LANES*BIT_CNT];
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        in_ready   = 1'b0;
        w_ren      = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_cnt == LOAD_W'(N_IN - 1)) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_ren = (issue_cnt < ISS_W'(CHUNKS));
                if (rd_valid && rd_chunk == ISS_W'(CHUNKS - 1)) begin
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (neuron == IDX_W'(N_OUT - 1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign w_addr   = row_addr;
    assign out_idx  = neuron;
    assign out_data = (state == S_EMIT) ? BIT_CNT'(sat_to_bit_cnt(32'(acc), BIT_CNT)) : '0;

    // Weight rows are laid out neuron-major, so one running address covers the whole layer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            load_cnt  <= '0;
            issue_cnt <= '0;
            rd_chunk  <= '0;
            rd_valid  <= 1'b0;
            row_addr  <= '0;
            neuron    <= '0;
            acc       <= '0;
        end else begin
            state    <= state_next;
            rd_valid <= w_ren;
            if (w_ren) begin
                rd_chunk  <= issue_cnt;
                issue_cnt <= issue_cnt + 1'b1;
                row_addr  <= row_addr + 1'b1;
            end
            if (rd_valid) begin
                acc <= acc + partial;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        load_cnt <= load_cnt + 1'b1;
                        if (load_cnt == LOAD_W'(N_IN - 1)) begin
                            neuron    <= '0;
                            row_addr  <= '0;
                            issue_cnt <= '0;
                            acc       <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready && neuron != IDX_W'(N_OUT - 1)) begin
                        neuron    <= neuron + 1'b1;
                        issue_cnt <= '0;
                        acc       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The activation buffer is fully rewritten each layer, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            for (int i = 0; i < N_IN; i++) begin
                if (load_cnt == LOAD_W'(i)) begin
                    act_flat[i*BIT_CNT +: BIT_CNT] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_layer_sequencer.sv
// Directed bench for bin_layer_sequencer with a 4-input, 2-lane, 2-neuron layer.
// Table-driven layers plus hand-written stall, load-gap and mid-layer reset sequences.
module tb_bin_layer_sequencer;

    localparam int BIT_CNT = 8;
    localparam int N_IN    = 4;
    localparam int LANES   = 2;
    localparam int N_OUT   = 2;
    localparam int CHUNKS  = N_IN / LANES;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      start = 1'b0;
    logic                      busy;
    logic                      done;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [BIT_CNT-1:0]        in_data = '0;
    logic                      w_ren;
    logic [1:0]                w_addr;
    logic [LANES-1:0]          w_rdata = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic signed [BIT_CNT-1:0] out_data;
    logic [0:0]                out_idx;

    logic [LANES-1:0] wmem [4];
    int n_checks = 0;
    int n_fail = 0;
    int done_count = 0;

    typedef struct packed {
        logic [3:0][7:0] act;
        logic [3:0][1:0] rows;
        logic [1:0][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    bin_layer_sequencer #(
        .BIT_CNT (BIT_CNT),
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .LANES   (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_ren     (w_ren),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    // Weight RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (w_ren) w_rdata <= wmem[w_addr];
    end

    always @(negedge clk) begin
        if (done) done_count++;
    end

    function automatic vec_t make_vec(input int a0, input int a1, input int a2, input int a3,
                                      input int r0, input int r1, input int r2, input int r3,
                                      input int e0, input int e1);
        vec_t v;
        v.act[0] = 8'(a0); v.act[1] = 8'(a1); v.act[2] = 8'(a2); v.act[3] = 8'(a3);
        v.rows[0] = 2'(r0); v.rows[1] = 2'(r1); v.rows[2] = 2'(r2); v.rows[3] = 2'(r3);
        v.exp[0] = 8'(e0); v.exp[1] = 8'(e1);
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Pulses start, writes the weight RAM and streams the activations (optionally with gaps).
    task automatic apply_stimulus(input vec_t v, input bit gaps, input bit stall);
        for (int r = 0; r < 4; r++) wmem[r] = v.rows[r];
        out_ready = !stall;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_in_load", int'(busy), 1);
        check("in_ready_in_load", int'(in_ready), 1);
        for (int i = 0; i < N_IN; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("in_ready_gap", int'(in_ready), 1);
            end
            in_valid = 1'b1;
            in_data  = v.act[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("in_ready_after_load", int'(in_ready), 0);
    endtask

    // Collects both neuron results, checking latency, values, stall behaviour and the done pulse.
    task automatic check_output(input vec_t v, input bit stall);
        int waits;
        int done_before;
        done_before = done_count;
        for (int n = 0; n < N_OUT; n++) begin
            waits = 0;
            while (!out_valid && waits < 30) begin
                @(negedge clk);
                waits++;
            end
            if (!out_valid) begin
                check("out_valid_timeout", int'(out_valid), 1);
                return;
            end
            check($sformatf("latency_n%0d", n), waits, CHUNKS + 1);
            check($sformatf("out_data_n%0d", n), int'(out_data), int'($signed(v.exp[n])));
            check($sformatf("out_idx_n%0d", n), int'(out_idx), n);
            if (stall && n == 0) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_out_valid", int'(out_valid), 1);
                    check("stall_out_data", int'(out_data), int'($signed(v.exp[0])));
                    check("stall_out_idx", int'(out_idx), 0);
                    check("stall_w_ren", int'(w_ren), 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("done_pulse", int'(done), 1);
        @(negedge clk);
        check("done_cleared", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("done_count", done_count - done_before, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_w_ren"}, int'(w_ren), 0);
        check({tag, "_w_addr"}, int'(w_addr), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_out_idx"}, int'(out_idx), 0);
    endtask

    initial begin
        int waits;
        vecs[0] = make_vec(3, -2, 5, 1,        3, 3, 0, 0,   7, -7);
        vecs[1] = make_vec(3, -2, 5, 1,        1, 2, 1, 1,   1, 9);
        vecs[2] = make_vec(127, 127, 127, 127, 3, 3, 0, 0,   127, -128);
        vecs[3] = make_vec(-128, -128, -128, -128, 3, 3, 0, 0, -128, 127);
        vecs[4] = make_vec(-128, 127, 0, -1,   2, 1, 1, 2,   127, -128);
        vecs[5] = make_vec(10, 20, -30, 40,    1, 0, 3, 2,   -20, 100);

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] layer vector %0d", i);
            apply_stimulus(vecs[i], 1'b0, 1'b0);
            check_output(vecs[i], 1'b0);
        end

        $display("[TB] output stall");
        apply_stimulus(vecs[1], 1'b0, 1'b1);
        check_output(vecs[1], 1'b1);

        $display("[TB] load gaps with stray start");
        apply_stimulus(vecs[5], 1'b1, 1'b0);
        check_output(vecs[5], 1'b0);

        $display("[TB] reset during second neuron fetch");
        apply_stimulus(vecs[0], 1'b0, 1'b0);
        waits = 0;
        while (!out_valid && waits < 30) begin
            @(negedge clk);
            waits++;
        end
        check("rst_seq_out_valid", int'(out_valid), 1);
        @(negedge clk);
        @(negedge clk);
        check("rst_seq_w_ren_before", int'(w_ren), 1);
        check("rst_seq_w_addr_before", int'(w_addr), 3);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", int'(busy), 0);
        apply_stimulus(vecs[0], 1'b0, 1'b0);
        check_output(vecs[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
